// File: rtl/menu_scene_if.sv
// Video timing, button and menu-status bundle for the menu background stage.
`timescale 1ns/1ps
interface menu_scene_if #(
  parameter int SEL_W = 2
);
  logic [10:0]      hcount_in;
  logic [10:0]      vcount_in;
  logic             hsync_in;
  logic             vsync_in;
  logic             hblnk_in;
  logic             vblnk_in;
  logic             btn_up;
  logic             btn_down;
  logic             btn_select;
  logic             menu_restart;
  logic [10:0]      hcount_out;
  logic [10:0]      vcount_out;
  logic             hsync_out;
  logic             vsync_out;
  logic             hblnk_out;
  logic             vblnk_out;
  logic [11:0]      rgb_out;
  logic [SEL_W-1:0] sel_item;
  logic             choice_valid;
  logic             menu_active;

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  btn_up, btn_down, btn_select, menu_restart,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, sel_item, choice_valid, menu_active
  );

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output btn_up, btn_down, btn_select, menu_restart,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, sel_item, choice_valid, menu_active
  );
endinterface

// File: rtl/menu_scene.sv
// Menu background stage: road scene with scrolling midline, button-driven item
// panel and a flashing confirm sequence; timing passes through with 1-cycle delay.
`timescale 1ns/1ps
module menu_scene #(
  parameter int          H_LAST       = 1023,
  parameter int          GRASS1_TOP   = 630,
  parameter int          ROAD_TOP     = 647,
  parameter int          ROAD_BOT     = 714,
  parameter int          GRASS2_BOT   = 762,
  parameter int          MID_TOP      = 679,
  parameter int          MID_BOT      = 682,
  parameter int          DASH_LEN     = 32,
  parameter int          DASH_PERIOD  = 64,
  parameter int          SCROLL_STEP  = 4,
  parameter int          MENU_X       = 11,
  parameter int          MENU_Y       = 12,
  parameter int          MENU_W       = 200,
  parameter int          MENU_H       = 256,
  parameter int          N_ITEMS      = 4,
  parameter int          ITEM_MARGIN  = 4,
  parameter int          SEL_W        = 2,
  parameter int          FLASH_FRAMES = 16,
  parameter logic [11:0] C_SKY        = 12'h5cf,
  parameter logic [11:0] C_GRASS      = 12'h494,
  parameter logic [11:0] C_ROAD       = 12'h9ab,
  parameter logic [11:0] C_MID        = 12'hff4,
  parameter logic [11:0] C_PANEL      = 12'hf52,
  parameter logic [11:0] C_ITEM       = 12'hfa6,
  parameter logic [11:0] C_SEL        = 12'hfff
) (
  input  logic      clk,
  input  logic      rst,
  menu_scene_if.slave bus
);
  localparam int SCW    = $clog2(DASH_PERIOD);
  localparam int FCW    = $clog2(FLASH_FRAMES + 1);
  localparam int ITEM_H = MENU_H / N_ITEMS;

  typedef enum logic [1:0] {
    ST_BROWSE = 2'd0,
    ST_FLASH  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [FCW-1:0]   r_cnt;
  logic             r_phase;
  logic             r_choice;
  logic             r_active;
  logic [SCW-1:0]   r_scroll;
  logic             r_vblnk_q;
  logic [1:0]       r_up_sync, r_dn_sync, r_sl_sync;
  logic             r_up_q, r_dn_q, r_sl_q;
  logic [10:0]      r_hcount, r_vcount;
  logic             r_hsync, r_vsync, r_hblnk, r_vblnk;
  logic [11:0]      r_rgb;

  logic             w_up_ev, w_dn_ev, w_sl_ev, w_tick;
  logic             w_in_panel, w_in_box;
  logic [SEL_W-1:0] w_box_idx;
  logic [SCW-1:0]   w_dash_pos;
  logic [11:0]      w_box_col, w_rgb;
  logic [10:0]      w_h, w_v;

  assign w_h        = bus.hcount_in;
  assign w_v        = bus.vcount_in;
  assign w_up_ev    = r_up_sync[1] & ~r_up_q;
  assign w_dn_ev    = r_dn_sync[1] & ~r_dn_q;
  assign w_sl_ev    = r_sl_sync[1] & ~r_sl_q;
  assign w_tick     = bus.vblnk_in & ~r_vblnk_q;
  assign w_dash_pos = w_h[SCW-1:0] + r_scroll;
  assign w_in_panel = (w_h >= 11'(MENU_X)) && (w_h < 11'(MENU_X + MENU_W)) &&
                      (w_v >= 11'(MENU_Y)) && (w_v < 11'(MENU_Y + MENU_H));

  // Button synchronizers and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up_sync <= 2'b00;
      r_dn_sync <= 2'b00;
      r_sl_sync <= 2'b00;
      r_up_q    <= 1'b0;
      r_dn_q    <= 1'b0;
      r_sl_q    <= 1'b0;
    end else begin
      r_up_sync <= {r_up_sync[0], bus.btn_up};
      r_dn_sync <= {r_dn_sync[0], bus.btn_down};
      r_sl_sync <= {r_sl_sync[0], bus.btn_select};
      r_up_q    <= r_up_sync[1];
      r_dn_q    <= r_dn_sync[1];
      r_sl_q    <= r_sl_sync[1];
    end
  end

  // Frame-tick detection and midline scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vblnk_q <= 1'b0;
      r_scroll  <= '0;
    end else begin
      r_vblnk_q <= bus.vblnk_in;
      if (w_tick) begin
        r_scroll <= r_scroll + SCW'(SCROLL_STEP);
      end else begin
        r_scroll <= r_scroll;
      end
    end
  end

  // Item box hit test by range comparison; slot index falls out of the loop.
  always_comb begin
    w_in_box  = 1'b0;
    w_box_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if ((w_v >= 11'(MENU_Y + i * ITEM_H + ITEM_MARGIN)) &&
          (w_v <= 11'(MENU_Y + (i + 1) * ITEM_H - ITEM_MARGIN - 1)) &&
          (w_h >= 11'(MENU_X + ITEM_MARGIN)) &&
          (w_h <= 11'(MENU_X + MENU_W - ITEM_MARGIN - 1))) begin
        w_in_box  = 1'b1;
        w_box_idx = SEL_W'(i);
      end else begin
        w_in_box  = w_in_box;
      end
    end
  end

  // Pixel color by layer priority.
  always_comb begin
    w_box_col = C_ITEM;
    w_rgb     = 12'h000;
    if (w_box_idx == r_sel) begin
      w_box_col = ((r_state == ST_FLASH) && r_phase) ? C_ITEM : C_SEL;
    end else begin
      w_box_col = C_ITEM;
    end
    if (bus.hblnk_in || bus.vblnk_in) begin
      w_rgb = 12'h000;
    end else if (w_in_panel && r_active) begin
      w_rgb = w_in_box ? w_box_col : C_PANEL;
    end else if (w_h > 11'(H_LAST)) begin
      w_rgb = 12'h000;
    end else if ((w_v >= 11'(MID_TOP)) && (w_v <= 11'(MID_BOT)) &&
                 (w_dash_pos < SCW'(DASH_LEN))) begin
      w_rgb = C_MID;
    end else if ((w_v >= 11'(ROAD_TOP)) && (w_v <= 11'(ROAD_BOT))) begin
      w_rgb = C_ROAD;
    end else if (((w_v >= 11'(GRASS1_TOP)) && (w_v < 11'(ROAD_TOP))) ||
                 ((w_v > 11'(ROAD_BOT)) && (w_v <= 11'(GRASS2_BOT)))) begin
      w_rgb = C_GRASS;
    end else if (w_v < 11'(GRASS1_TOP)) begin
      w_rgb = C_SKY;
    end else begin
      w_rgb = 12'h000;
    end
  end

  // Timing passthrough with the pixel color aligned to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= 11'd0;
      r_vcount <= 11'd0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_rgb    <= 12'h000;
    end else begin
      r_hcount <= w_h;
      r_vcount <= w_v;
      r_hsync  <= bus.hsync_in;
      r_vsync  <= bus.vsync_in;
      r_hblnk  <= bus.hblnk_in;
      r_vblnk  <= bus.vblnk_in;
      r_rgb    <= w_rgb;
    end
  end

  // Menu FSM; restart overrides everything, including a final flash tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_BROWSE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_choice <= 1'b0;
      r_active <= 1'b1;
    end else begin
      r_choice <= 1'b0;
      if (bus.menu_restart) begin
        r_state  <= ST_BROWSE;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
        r_active <= 1'b1;
      end else begin
        case (r_state)
          ST_BROWSE: begin
            if (w_sl_ev) begin
              r_state <= ST_FLASH;
              r_cnt   <= FCW'(FLASH_FRAMES);
              r_phase <= 1'b0;
            end else if (w_up_ev && !w_dn_ev) begin
              r_sel <= (r_sel == '0) ? SEL_W'(N_ITEMS - 1) : r_sel - SEL_W'(1);
            end else if (w_dn_ev && !w_up_ev) begin
              r_sel <= (r_sel == SEL_W'(N_ITEMS - 1)) ? '0 : r_sel + SEL_W'(1);
            end else begin
              r_sel <= r_sel;
            end
          end
          ST_FLASH: begin
            if (w_tick) begin
              r_phase <= ~r_phase;
              r_cnt   <= r_cnt - FCW'(1);
              if (r_cnt == FCW'(1)) begin
                r_state  <= ST_DONE;
                r_choice <= 1'b1;
                r_active <= 1'b0;
              end else begin
                r_state  <= ST_FLASH;
              end
            end else begin
              r_state <= ST_FLASH;
            end
          end
          ST_DONE: begin
            r_state  <= ST_DONE;
            r_active <= 1'b0;
          end
          default: begin
            r_state  <= ST_BROWSE;
            r_active <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.hcount_out   = r_hcount;
  assign bus.vcount_out   = r_vcount;
  assign bus.hsync_out    = r_hsync;
  assign bus.vsync_out    = r_vsync;
  assign bus.hblnk_out    = r_hblnk;
  assign bus.vblnk_out    = r_vblnk;
  assign bus.rgb_out      = r_rgb;
  assign bus.sel_item     = r_sel;
  assign bus.choice_valid = r_choice;
  assign bus.menu_active  = r_active;
endmodule

// File: tb/tb_menu_scene.sv
// Directed-vector bench for menu_scene with hand-computed expected values.
`timescale 1ns/1ps
module tb_menu_scene;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cv_cnt = 0;

  menu_scene_if #(.SEL_W(2)) bus ();

  menu_scene dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.choice_valid === 1'b1) cv_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and wait for its registered result.
  task automatic pix(input int h, input int v, input bit hb);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 11'(v);
    bus.hblnk_in  = hb;
    bus.vblnk_in  = 1'b0;
    step();
  endtask

  task automatic tick();
    bus.vblnk_in = 1'b1;
    step();
    bus.vblnk_in = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // 0 up, 1 down, 2 select, 3 up+down together
  task automatic press(input int which, input int hold);
    bus.btn_up     = (which == 0 || which == 3);
    bus.btn_down   = (which == 1 || which == 3);
    bus.btn_select = (which == 2);
    repeat (hold) step();
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_select = 1'b0;
    repeat (6) step();
  endtask

  task automatic restart();
    bus.menu_restart = 1'b1;
    step();
    bus.menu_restart = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.hcount_in = 11'd0;  bus.vcount_in = 11'd0;
    bus.hsync_in = 1'b0;    bus.vsync_in = 1'b0;
    bus.hblnk_in = 1'b0;    bus.vblnk_in = 1'b0;
    bus.btn_up = 1'b0;      bus.btn_down = 1'b0;
    bus.btn_select = 1'b0;  bus.menu_restart = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Move away from reset state, then reset asynchronously mid-cycle.
    press(1, 5);
    pix(500, 0, 1'b0);
    chk("pre_sel", 32'(bus.sel_item), 32'd1);
    chk("pre_hcnt", 32'(bus.hcount_out), 32'd500);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_sel", 32'(bus.sel_item), 32'd0);
    chk("rst_active", 32'(bus.menu_active), 32'd1);
    chk("rst_rgb", 32'(bus.rgb_out), 32'h000);
    chk("rst_hcnt", 32'(bus.hcount_out), 32'd0);
    chk("rst_cv", 32'(bus.choice_valid), 32'd0);
    step();
    rst = 1'b0;

    // Panel with item 0 selected: box 0 rows 16..71, box 1 rows 80..135.
    pix(100, 40, 1'b0);  chk("item0_sel", 32'(bus.rgb_out), 32'hfff);
    pix(100, 100, 1'b0); chk("item1_unsel", 32'(bus.rgb_out), 32'hfa6);
    pix(100, 13, 1'b0);  chk("panel_margin", 32'(bus.rgb_out), 32'hf52);
    pix(14, 40, 1'b0);   chk("panel_left", 32'(bus.rgb_out), 32'hf52);

    // Background bands and timing passthrough.
    pix(500, 0, 1'b0);   chk("sky", 32'(bus.rgb_out), 32'h5cf);
    chk("hcnt_out", 32'(bus.hcount_out), 32'd500);
    chk("vcnt_out", 32'(bus.vcount_out), 32'd0);
    pix(500, 700, 1'b0); chk("road", 32'(bus.rgb_out), 32'h9ab);
    pix(500, 640, 1'b0); chk("grass1", 32'(bus.rgb_out), 32'h494);
    pix(500, 740, 1'b0); chk("grass2", 32'(bus.rgb_out), 32'h494);
    pix(500, 765, 1'b0); chk("below", 32'(bus.rgb_out), 32'h000);
    pix(1030, 100, 1'b0); chk("beyond_h", 32'(bus.rgb_out), 32'h000);
    pix(500, 0, 1'b1);   chk("hblnk", 32'(bus.rgb_out), 32'h000);
    chk("hblnk_out", 32'(bus.hblnk_out), 32'd1);
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    pix(500, 0, 1'b0);
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    chk("hsync_out", 32'(bus.hsync_out), 32'd1);
    chk("vsync_out", 32'(bus.vsync_out), 32'd1);
    pix(500, 0, 1'b0);   chk("hsync_low", 32'(bus.hsync_out), 32'd0);

    // Midline scroll.
    pix(0, 680, 1'b0);   chk("mid_f0", 32'(bus.rgb_out), 32'hff4);
    pix(31, 680, 1'b0);  chk("mid_f0_31", 32'(bus.rgb_out), 32'hff4);
    pix(32, 680, 1'b0);  chk("mid_f0_32", 32'(bus.rgb_out), 32'h9ab);
    ticks(8);
    pix(0, 680, 1'b0);   chk("mid_f8", 32'(bus.rgb_out), 32'h9ab);
    pix(32, 680, 1'b0);  chk("mid_f8_32", 32'(bus.rgb_out), 32'hff4);
    ticks(8);
    pix(0, 680, 1'b0);   chk("mid_f16", 32'(bus.rgb_out), 32'hff4);

    // Cursor movement and wrap.
    press(1, 5); chk("dn1", 32'(bus.sel_item), 32'd1);
    press(1, 5); chk("dn2", 32'(bus.sel_item), 32'd2);
    press(1, 5); chk("dn3", 32'(bus.sel_item), 32'd3);
    press(0, 5); chk("up1", 32'(bus.sel_item), 32'd2);
    press(1, 5); chk("dn4", 32'(bus.sel_item), 32'd3);
    press(1, 5); chk("wrap_dn", 32'(bus.sel_item), 32'd0);
    press(0, 5); chk("wrap_up", 32'(bus.sel_item), 32'd3);
    press(1, 1000); chk("hold", 32'(bus.sel_item), 32'd0);
    press(3, 5); chk("both", 32'(bus.sel_item), 32'd0);
    press(1, 5); press(1, 5); chk("to2", 32'(bus.sel_item), 32'd2);

    // Confirm flash on item 2 (box rows 144..199).
    cv_cnt = 0;
    press(2, 5);
    pix(100, 150, 1'b0); chk("flash_p0", 32'(bus.rgb_out), 32'hfff);
    tick();
    pix(100, 150, 1'b0); chk("flash_p1", 32'(bus.rgb_out), 32'hfa6);
    tick();
    pix(100, 150, 1'b0); chk("flash_p2", 32'(bus.rgb_out), 32'hfff);
    press(0, 5); press(1, 5); press(2, 5);
    chk("flash_sel_hold", 32'(bus.sel_item), 32'd2);
    ticks(13);
    chk("flash_15_active", 32'(bus.menu_active), 32'd1);
    chk("flash_15_cv", 32'(cv_cnt), 32'd0);
    tick();
    chk("done_active", 32'(bus.menu_active), 32'd0);
    chk("done_cv", 32'(cv_cnt), 32'd1);
    repeat (20) step();
    chk("done_cv_once", 32'(cv_cnt), 32'd1);
    pix(100, 100, 1'b0); chk("done_sky", 32'(bus.rgb_out), 32'h5cf);
    pix(100, 150, 1'b0); chk("done_sky2", 32'(bus.rgb_out), 32'h5cf);
    restart();
    chk("restart_active", 32'(bus.menu_active), 32'd1);
    chk("restart_sel", 32'(bus.sel_item), 32'd2);
    pix(100, 150, 1'b0); chk("restart_box", 32'(bus.rgb_out), 32'hfff);

    // Abort a flash part way through.
    cv_cnt = 0;
    press(2, 5);
    ticks(5);
    pix(100, 150, 1'b0); chk("abort_phase", 32'(bus.rgb_out), 32'hfa6);
    restart();
    ticks(20);
    chk("abort_cv", 32'(cv_cnt), 32'd0);
    chk("abort_active", 32'(bus.menu_active), 32'd1);
    pix(100, 150, 1'b0); chk("abort_box", 32'(bus.rgb_out), 32'hfff);
    press(1, 5); chk("abort_browse", 32'(bus.sel_item), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
